// File: rtl/cdma_seq_ctrl.sv
// cdma_seq_ctrl: frame sequencer that spreads one byte MSB-first over gold-code chips
module cdma_seq_ctrl #(
  parameter int CHIPS_PER_BIT = 31,
  parameter int PRESCALE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  input  logic [7:0] data_i,
  input  logic [4:0] seed_i,
  input  logic       abort_i,
  output logic       load_o,
  output logic [4:0] seed_o,
  output logic       chip_en_o,
  output logic       signal_o,
  output logic [2:0] bit_idx_o,
  output logic       busy_o,
  output logic       frame_done_o
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int CW = CHIPS_PER_BIT > 1 ? $clog2(CHIPS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic [CW-1:0] chip_cnt;
  logic [7:0] data_q;
  logic [4:0] seed_q;
  logic [2:0] bit_idx;
  logic accept, chip_en, last_chip;
  assign accept = data_valid_i && state == IDLE;
  assign chip_en = state == SEND && presc == PW'(PRESCALE - 1);
  assign last_chip = chip_en && chip_cnt == CW'(CHIPS_PER_BIT - 1);
  // state register; reset dominates everything
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  end
  // next state; abort pulls any active frame back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? LOAD : IDLE;
      LOAD: state_nx = SEND;
      SEND: state_nx = (last_chip && bit_idx == 3'd0) ? DONE : SEND;
      default: state_nx = IDLE;
    endcase
    if (abort_i && state != IDLE) state_nx = IDLE;
  end
  // frame capture, chip prescaler and bit/chip counters
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_q <= '0;
      seed_q <= '0;
      presc <= '0;
      chip_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if (accept) begin
        data_q <= data_i;
        seed_q <= seed_i;
      end
      if (state == LOAD) begin
        presc <= '0;
        chip_cnt <= '0;
        bit_idx <= 3'd7;
      end else if (state == SEND) begin
        presc <= chip_en ? '0 : presc + 1'b1;
        if (chip_en) chip_cnt <= last_chip ? '0 : chip_cnt + 1'b1;
        if (last_chip && bit_idx != 3'd0) bit_idx <= bit_idx - 1'b1;
      end
    end
  end
  // Moore outputs decoded from state and counters
  always_comb begin
    data_ready_o = state == IDLE;
    load_o = state == LOAD;
    seed_o = seed_q;
    chip_en_o = chip_en;
    signal_o = state == SEND ? data_q[bit_idx] : 1'b0;
    bit_idx_o = bit_idx;
    busy_o = state != IDLE;
    frame_done_o = state == DONE;
  end
endmodule

// File: tb/tb_cdma_seq_ctrl.sv
// tb_cdma_seq_ctrl: default instance and a PRESCALE=1/CHIPS_PER_BIT=3 instance checked against a timeline model
module tb_cdma_seq_ctrl;
  logic clk = 0, rst = 0, valid = 0, abort = 0;
  logic [7:0] data = 0;
  logic [4:0] seed = 0;
  logic rdy[2], ld[2], ce[2], sg[2], bsy[2], dn[2];
  logic [4:0] so[2];
  logic [2:0] bi[2];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ph[2] = '{-1, -1};
  logic [7:0] md[2];
  logic [4:0] ms[2];
  bit bk[2];

  typedef struct {
    logic rst, v, ab;
    logic [7:0] d;
    logic [4:0] s;
    logic [13:0] e;
    logic mb;
  } vec_t;
  vec_t tbl[10];

  cdma_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .data_valid_i(valid), .data_ready_o(rdy[0]), .data_i(data),
    .seed_i(seed), .abort_i(abort), .load_o(ld[0]), .seed_o(so[0]), .chip_en_o(ce[0]),
    .signal_o(sg[0]), .bit_idx_o(bi[0]), .busy_o(bsy[0]), .frame_done_o(dn[0])
  );
  cdma_seq_ctrl #(.CHIPS_PER_BIT(3), .PRESCALE(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .data_valid_i(valid), .data_ready_o(rdy[1]), .data_i(data),
    .seed_i(seed), .abort_i(abort), .load_o(ld[1]), .seed_o(so[1]), .chip_en_o(ce[1]),
    .signal_o(sg[1]), .bit_idx_o(bi[1]), .busy_o(bsy[1]), .frame_done_o(dn[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int pp(int i);
    return i == 0 ? 4 : 1;
  endfunction
  function automatic int cc(int i);
    return i == 0 ? 31 : 3;
  endfunction

  function automatic logic [13:0] mk(bit r, bit l, logic [4:0] s, bit c, bit g, logic [2:0] b, bit y, bit d);
    return {r, l, s, c, g, b, y, d};
  endfunction

  function automatic logic [13:0] act(int i);
    return {rdy[i], ld[i], so[i], ce[i], sg[i], bi[i], bsy[i], dn[i]};
  endfunction

  // ph = cycles since the accepting edge: 1 = seed load, 2..1+8PC = chips, 2+8PC = done
  function automatic logic [13:0] expv(int i);
    int p = pp(i), c = cc(i), l = 8 * p * c, j = ph[i] - 2, b = 0;
    bit snd = ph[i] >= 2 && ph[i] <= l + 1;
    if (snd) b = 7 - j / (p * c);
    return {ph[i] == -1, ph[i] == 1, ms[i], snd && (j % p == p - 1), snd && md[i][b], 3'(b),
            ph[i] != -1, ph[i] == l + 2};
  endfunction

  function automatic logic [13:0] mask(int i);
    int l = 8 * pp(i) * cc(i);
    return (ph[i] >= 2 || bk[i]) ? 14'h3FFF : 14'h3FE3;
  endfunction

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e, input logic [31:0] m = '1);
    n_chk++;
    if (((a ^ e) & m) != 0) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a & m, e & m);
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      int l = 8 * pp(i) * cc(i);
      if (!rst) begin
        ph[i] = -1;
        ms[i] = 0;
        bk[i] = 1;
      end else if (ph[i] == -1) begin
        if (valid) begin
          ph[i] = 1;
          md[i] = data;
          ms[i] = seed;
        end
      end else if (abort || ph[i] == l + 2) begin
        bk[i] = ph[i] == l + 2;
        ph[i] = -1;
      end else ph[i]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
    cyc++;
    check("model0", act(0), expv(0), mask(0));
    check("model1", act(1), expv(1), mask(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy[0] && rdy[1]) && n < 3000) begin
      tick();
      n++;
    end
    check("wait_idle", rdy[0] && rdy[1], 1);
  endtask

  task automatic run_default();
    int t, first = -1, nstb = 0, serr = 0, done_c = -1, rdy_c = -1;
    logic [7:0] pat = 8'hA5;
    wait_idle();
    valid = 1; data = 8'hA5; seed = 5'h1F; t = cyc;
    tick();
    valid = 0; data = 8'h00; seed = 5'h00;
    check("load_t", ld[0], 1);
    check("load_seed", so[0], 5'h1F);
    for (int n = 0; n < 1100 && rdy_c < 0; n++) begin
      tick();
      if (ce[0]) begin
        if (first < 0) first = cyc - t;
        if (nstb < 248 && sg[0] != pat[7 - nstb / 31]) serr++;
        nstb++;
      end
      if (dn[0]) done_c = cyc - t;
      if (rdy[0] && done_c >= 0) rdy_c = cyc - t;
    end
    check("first_chip", first, 5);
    check("strobes", nstb, 248);
    check("sig_pattern", serr, 0);
    check("done_t", done_c, 994);
    check("ready_t", rdy_c, 995);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'h00, mk(1, 0, 5'h00, 0, 0, 3'd0, 0, 0), 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h80, 5'h0A, mk(0, 1, 5'h0A, 0, 0, 3'd0, 1, 0), 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'hFF, 5'h11, mk(0, 0, 5'h0A, 1, 1, 3'd7, 1, 0), 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, mk(0, 0, 5'h0A, 1, 1, 3'd7, 1, 0), 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, mk(0, 0, 5'h0A, 1, 1, 3'd7, 1, 0), 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, mk(0, 0, 5'h0A, 1, 0, 3'd6, 1, 0), 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h00, 5'h00, mk(1, 0, 5'h0A, 0, 0, 3'd0, 0, 0), 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h01, 5'h03, mk(0, 1, 5'h03, 0, 0, 3'd0, 1, 0), 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'h00, mk(1, 0, 5'h00, 0, 0, 3'd0, 0, 0), 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, mk(1, 0, 5'h00, 0, 0, 3'd0, 0, 0), 1'b1};
    for (int k = 0; k < 10; k++) begin
      rst = tbl[k].rst; valid = tbl[k].v; abort = tbl[k].ab; data = tbl[k].d; seed = tbl[k].s;
      tick();
      check($sformatf("vec%0d", k), act(1), tbl[k].e, tbl[k].mb ? 14'h3FFF : 14'h3FE3);
    end
    rst = 1; valid = 0; abort = 0;

    // short-frame instance: 24 back-to-back strobes, only bit 7 set
    begin
      int t, first = -1, last = -1, n = 0, ones = 0, ones3 = 0;
      wait_idle();
      valid = 1; data = 8'h80; seed = 5'h04; t = cyc;
      tick();
      valid = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (ce[1]) begin
          if (first < 0) first = cyc - t;
          last = cyc - t;
          if (sg[1]) begin
            ones++;
            if (n < 3) ones3++;
          end
          n++;
        end
      end
      check("p1_first", first, 2);
      check("p1_last", last, 25);
      check("p1_count", n, 24);
      check("p1_ones", ones, 3);
      check("p1_ones_first3", ones3, 3);
    end

    run_default();

    // abort after 100 strobes, then a clean frame
    begin
      int n = 0, nc = 0, nd = 0, nl = 0;
      wait_idle();
      valid = 1; data = 8'h3C; seed = 5'h07;
      tick();
      valid = 0;
      for (int k = 0; k < 1000 && n < 100; k++) begin
        tick();
        if (ce[0]) n++;
      end
      check("abort_reach", n, 100);
      abort = 1;
      tick();
      abort = 0;
      check("abort_idle", {rdy[0], bsy[0]}, 2'b10);
      repeat (1100) begin
        tick();
        nc += int'(ce[0]);
        nd += int'(dn[0]);
        nl += int'(ld[0]);
      end
      check("abort_no_chip", nc, 0);
      check("abort_no_done", nd, 0);
      check("abort_no_load", nl, 0);
      run_default();
    end

    // one-cycle reset mid-SEND with data_valid held high
    begin
      wait_idle();
      valid = 1; data = 8'hC3; seed = 5'h09;
      tick();
      valid = 0;
      repeat (50) tick();
      rst = 0; valid = 1; data = 8'h66; seed = 5'h15;
      tick();
      check("rst_vals0", act(0), mk(1, 0, 5'h00, 0, 0, 3'd0, 0, 0));
      check("rst_vals1", act(1), mk(1, 0, 5'h00, 0, 0, 3'd0, 0, 0));
      rst = 1;
      tick();
      check("accept_after_rst", {ld[0], so[0]}, {1'b1, 5'h15});
      valid = 0;
    end

    // valid held high with changing data: second frame taken exactly when ready returns
    begin
      int t, r = -1;
      logic [4:0] sr;
      wait_idle();
      valid = 1; data = 8'h5A; seed = 5'h02; t = cyc;
      tick();
      for (int n = 0; n < 1100 && r < 0; n++) begin
        data = 8'($urandom); seed = 5'($urandom);
        tick();
        if (rdy[0]) r = cyc;
      end
      check("ready_return", r - t, 995);
      data = 8'($urandom); seed = 5'($urandom); sr = seed;
      tick();
      check("second_accept", {ld[0], so[0]}, {1'b1, sr});
      valid = 0;
    end

    for (int n = 0; n < 12000; n++) begin
      rst = $urandom_range(0, 2999) != 0;
      valid = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 499) == 0;
      data = 8'($urandom);
      seed = 5'($urandom);
      tick();
    end
    rst = 1; valid = 0; abort = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdma_seq_ctrl.md
CDMA_SEQ_CTRL -- requirements
Module: cdma_seq_ctrl

Interface
REQ-001 Parameter CHIPS_PER_BIT, default 31, chips transmitted per data bit (legal >= 1).
REQ-002 Parameter PRESCALE, default 4, clock cycles per chip (legal >= 1).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-low reset.
REQ-005 data_valid_i  input  1  requester holds data_i/seed_i valid.
REQ-006 data_ready_o  output  1  controller can accept a frame.
REQ-007 data_i  input  8  frame byte, sent MSB first.
REQ-008 seed_i  input  5  gold-code seed for this frame.
REQ-009 abort_i  input  1  synchronous frame abort.
REQ-010 load_o  output  1  one-cycle seed-load strobe to the CDMA datapath.
REQ-011 seed_o  output  5  captured seed, held stable from LOAD until the next accept.
REQ-012 chip_en_o  output  1  one-cycle chip-advance strobe to the gold generator.
REQ-013 signal_o  output  1  current data bit presented to the spreader.
REQ-014 bit_idx_o  output  3  index of the bit being spread.
REQ-015 busy_o  output  1  high in any state other than IDLE.
REQ-016 frame_done_o  output  1  one-cycle strobe on frame completion.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SEND and DONE.
REQ-018 data_ready_o SHALL be 1 only in IDLE; accept = data_valid_i & data_ready_o.
REQ-019 On accept: capture data_i and seed_i, go to LOAD next cycle.
REQ-020 LOAD lasts exactly one cycle: load_o=1, seed_o=captured seed; next state SEND; prescaler=0, chip counter=0, bit_idx=7.
REQ-021 SEND: prescaler counts 0..PRESCALE-1 and wraps; chip_en_o=1 exactly in cycles where prescaler==PRESCALE-1.
REQ-022 Each chip_en_o increments the chip counter; on chip_en_o with counter==CHIPS_PER_BIT-1, counter wraps to 0 and bit_idx decrements.
REQ-023 On chip_en_o with counter==CHIPS_PER_BIT-1 and bit_idx==0, next state SHALL be DONE.
REQ-024 signal_o SHALL equal captured_data[bit_idx_o] in SEND and 0 otherwise.
REQ-025 DONE lasts one cycle with frame_done_o=1, then returns to IDLE.
REQ-026 Timing: accept at cycle T -> load_o at T+1 -> first chip_en_o at T+1+PRESCALE -> exactly 8*CHIPS_PER_BIT strobes per frame -> frame_done_o one cycle after the last strobe -> data_ready_o one cycle after that.
REQ-027 PRESCALE=1 SHALL give chip_en_o on every SEND cycle.
REQ-028 abort_i=1 in LOAD, SEND or DONE SHALL force IDLE next cycle; no further chip_en_o, load_o or frame_done_o for that frame.
REQ-029 abort_i in IDLE SHALL be ignored; abort_i with data_valid_i in IDLE SHALL still accept.
REQ-030 data_i, seed_i and data_valid_i changes while busy SHALL have no effect.
REQ-031 No back-to-back overlap: a new frame is accepted no earlier than the cycle after DONE.

Reset
REQ-032 rst_i=0 at a clock edge SHALL force IDLE, regardless of state; reset dominates abort_i and data_valid_i.
REQ-033 Reset values: data_ready_o=1 after the reset cycle, load_o=0, seed_o=0, chip_en_o=0, signal_o=0, bit_idx_o=0, busy_o=0, frame_done_o=0; counters 0.
REQ-034 Reset mid-SEND SHALL emit no further strobes; the partial frame is discarded.

Verification
REQ-035 Defaults, data_i=0xA5, seed_i=0x1F accepted at T -> load_o at T+1 with seed_o=0x1F; first chip_en_o at T+5; 248 strobes; signal_o pattern 1,0,1,0,0,1,0,1 in 31-strobe groups; frame_done_o at T+994; data_ready_o at T+995.
REQ-036 PRESCALE=1, CHIPS_PER_BIT=3, data_i=0x80 -> 24 consecutive chip_en_o cycles; signal_o=1 for the first 3 strobes, then 0.
REQ-037 abort_i pulsed after 100 chip_en_o -> IDLE next cycle; no further chip_en_o; frame_done_o never asserted; the next accept behaves as in REQ-035.
REQ-038 rst_i=0 for one cycle mid-SEND -> all outputs at reset values the next cycle; data_valid_i held high during reset is not accepted until rst_i=1.
REQ-039 data_valid_i held high continuously with new data_i during a frame -> the in-flight frame is unchanged; a second frame is accepted exactly at the cycle data_ready_o returns to 1.
